// File: rtl/aes_round_scheduler_pkg.sv
// Shared definitions for the AES round scheduler.
//   - sched_state_e : scheduler FSM states (IDLE/LOAD/ROUND/DONE)
//   - AES*_ROUNDS   : round counts for the three AES key sizes
package aes_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } sched_state_e;

    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;

endpackage

// File: rtl/aes_round_scheduler_if.sv
// Requester / datapath control bundle of the AES round scheduler.
//   master : requester and result-consumer side (drives req_valid, done_ready)
//   slave  : scheduler side (drives grants, datapath controls, completion)
interface aes_round_scheduler_if #(
    parameter int NUM_REQ = 2,
    parameter int CNT_W   = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic               ld;
    logic               round_en;
    logic [CNT_W-1:0]   round_cnt;
    logic               first_round;
    logic               last_round;
    logic               busy;
    logic               done_valid;
    logic [ID_W-1:0]    done_id;
    logic               done_ready;

    modport master (
        output req_valid, done_ready,
        input  req_ready, ld, round_en, round_cnt, first_round,
               last_round, busy, done_valid, done_id
    );

    modport slave (
        input  req_valid, done_ready,
        output req_ready, ld, round_en, round_cnt, first_round,
               last_round, busy, done_valid, done_id
    );
endinterface

// File: rtl/aes_round_scheduler_rr_arbiter.sv
// Rotating-priority arbiter.
//   req     : request vector
//   advance : a grant was accepted this cycle; move priority past the winner
//   gnt     : one-hot grant (combinational from req and the priority pointer)
//   gnt_idx : encoded index of gnt
// After reset index 0 has highest priority.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);
    localparam int IW1 = IW + 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW:0]   sum_v;
    logic [IW-1:0] idx_v;
    logic          found_v;

    // Scan from the priority pointer, wrapping modulo N, and take the first requester.
    always_comb begin
        gnt     = {N{1'b0}};
        gnt_idx = {IW{1'b0}};
        found_v = 1'b0;
        sum_v   = {IW1{1'b0}};
        idx_v   = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            sum_v = {1'b0, ptr_q} + IW1'(i);
            if (sum_v >= IW1'(N)) begin
                sum_v = sum_v - IW1'(N);
            end else begin
                sum_v = sum_v;
            end
            idx_v = sum_v[IW-1:0];
            if (!found_v && req[idx_v]) begin
                gnt[idx_v] = 1'b1;
                gnt_idx    = idx_v;
                found_v    = 1'b1;
            end else begin
                found_v = found_v;
            end
        end
    end

    // Next priority: the requester after the winner, only on an accepted grant.
    always_comb begin
        if (advance) begin
            if (gnt_idx == IW'(N - 1)) begin
                ptr_d = {IW{1'b0}};
            end else begin
                ptr_d = gnt_idx + IW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {IW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/aes_round_scheduler.sv
// AES round scheduler: arbitrates requesters onto one iterative AES round
// datapath, sequences load / rounds / completion.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester handshake, datapath controls (ld, round_en,
//              round_cnt, first_round, last_round), busy and the
//              completion handshake (done_valid/done_id/done_ready)
// All outputs except req_ready are decoded from registered state.
module aes_round_scheduler
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int CNT_W      = 4,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    aes_round_scheduler_if.slave bus
);
    sched_state_e       state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic               advance_s;

    // Any valid request in IDLE completes a transfer this cycle.
    assign advance_s = (state_q == S_IDLE) && (|bus.req_valid);

    rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .advance (advance_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Next-state, round counter and owner capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        case (state_q)
            S_IDLE: begin
                if (advance_s) begin
                    state_d = S_LOAD;
                    owner_d = gnt_idx_s;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                state_d = S_ROUND;
                cnt_d   = CNT_W'(1);
            end
            S_ROUND: begin
                // >= rather than == so a corrupted counter still terminates.
                if (cnt_q >= CNT_W'(NUM_ROUNDS)) begin
                    state_d = S_DONE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (bus.done_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                owner_d = {ID_W{1'b0}};
            end
        endcase
    end

    // State, counter and owner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            owner_q <= {ID_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    // Output decode from registered state; only req_ready sees req_valid.
    always_comb begin
        bus.req_ready   = {NUM_REQ{1'b0}};
        bus.ld          = 1'b0;
        bus.round_en    = 1'b0;
        bus.first_round = 1'b0;
        bus.last_round  = 1'b0;
        bus.busy        = 1'b0;
        bus.done_valid  = 1'b0;
        bus.done_id     = {ID_W{1'b0}};
        bus.round_cnt   = cnt_q;
        case (state_q)
            S_IDLE: begin
                bus.req_ready = gnt_s;
            end
            S_LOAD: begin
                bus.ld   = 1'b1;
                bus.busy = 1'b1;
            end
            S_ROUND: begin
                bus.round_en    = 1'b1;
                bus.busy        = 1'b1;
                bus.first_round = (cnt_q == CNT_W'(1));
                bus.last_round  = (cnt_q == CNT_W'(NUM_ROUNDS));
            end
            S_DONE: begin
                bus.busy       = 1'b1;
                bus.done_valid = 1'b1;
                bus.done_id    = owner_q;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end
endmodule

// File: doc/aes_round_scheduler.md
# aes_round_scheduler

Control block that shares one iterative AES-128 round datapath (the `aes_cipher_top` core) between several block-encryption requesters. It runs round-robin arbitration, issues the datapath's load strobe, and sequences the round counter through the initial and final rounds. It then holds a completion handshake until the owning requester collects its result. It sits between the requester-side bus adapters and the cipher core, and it is the only driver of the core's `ld` and round-select controls.

## Interface
- `NUM_REQ`, default 2: number of requesters (2..8).
- `NUM_ROUNDS`, default 10: AES rounds per block (10/12/14).
- `CNT_W`, default 4: round counter width; must satisfy 2^CNT_W > NUM_ROUNDS.
- `ID_W`, default $clog2(NUM_REQ): requester index width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: per-requester block ready to encrypt.
- `req_ready` out NUM_REQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `ld` out 1: one-cycle load strobe to the datapath (latch key and text).
- `round_en` out 1: datapath performs one round this cycle.
- `round_cnt` out CNT_W: current round number.
- `first_round` out 1: `round_cnt == 1` while `round_en` is high.
- `last_round` out 1: `round_cnt == NUM_ROUNDS` while `round_en` is high (skip MixColumns).
- `busy` out 1: high in any state other than IDLE.
- `done_valid` out 1: result available in the datapath output register.
- `done_id` out ID_W: index of the requester that owns the result.
- `done_ready` in 1: consumer accepts the result.

## Operation
- States: IDLE, LOAD, ROUND, DONE.
- **IDLE:** `req_ready` is the one-hot grant from the round-robin arbiter. If any `req_valid` is high, the transfer completes in this cycle, the granted index is latched into `owner`, and the FSM moves to LOAD.
- **LOAD:** `ld` = 1 and `round_cnt` = 0. Next state is ROUND with `round_cnt` = 1.
- **ROUND:** `round_en` = 1. `round_cnt` increments each cycle. When `round_cnt == NUM_ROUNDS`, `last_round` is high and the next state is DONE.
- **DONE:** `done_valid` = 1 and `done_id` = `owner`, both held stable until `done_ready`. On `done_valid & done_ready`, the FSM returns to IDLE.
- **Arbitration:** rotating priority. The requester after the last granted index has highest priority. After reset, index 0 has highest priority. The priority pointer updates only on a completed grant.
- `req_ready` is all-zero outside IDLE. It may depend combinationally on `req_valid` within IDLE; it never depends on `done_ready`.
- Outputs `ld`, `round_en`, `first_round` and `last_round` are mutually consistent: `ld` and `round_en` are never high together.
- **Reset values:** state IDLE, `req_ready` 0, `ld` 0, `round_en` 0, `round_cnt` 0, `first_round` 0, `last_round` 0, `busy` 0, `done_valid` 0, `done_id` 0, priority pointer selects index 0.
- **Reset mid-operation:** all of the above apply immediately (asynchronously). The datapath result is discarded and no `done_valid` is produced.
- **Requester behaviour:** a `req_valid` withdrawn before grant is ignored. A requester holding `req_valid` across its own completion competes again normally.
- **Counter overflow:** `round_cnt` never exceeds NUM_ROUNDS. Any illegal state encoding recovers to IDLE.

## Timing
- Grant at edge T (IDLE cycle):
  - LOAD in cycle T+1.
  - `round_en` in cycles T+2 through T+1+NUM_ROUNDS.
  - `done_valid` rises in cycle T+2+NUM_ROUNDS (cycle 12 for the default configuration).
- With `done_ready` tied high, DONE lasts 1 cycle and the next grant occurs in the following IDLE cycle. Minimum spacing between grants is NUM_ROUNDS+3 cycles.
- All outputs except `req_ready` are registered or decoded from registered state only.

## Structure
- Package `aes_sched_pkg` holds:
  - the state enum (IDLE/LOAD/ROUND/DONE);
  - `AES128_ROUNDS` = 10, `AES192_ROUNDS` = 12 and `AES256_ROUNDS` = 14.
- Sub-module `rr_arbiter` (parameter N) provides:
  - inputs `req[N]`, `advance`;
  - output one-hot `gnt[N]` and the encoded `gnt_idx`;
  - internal priority pointer, with the same reset behaviour.
- The top level contains the FSM, round counter and owner register.

## Test plan
- **Single request:** `req_valid` = 01 at cycle 0 with `done_ready` = 1 → `req_ready` = 01 at cycle 0; `ld` at cycle 1; `round_en` cycles 2–11 with `first_round` at 2 and `last_round` at 11; `done_valid` with `done_id` = 0 at cycle 12.
- **Contention:** `req_valid` = 11 held continuously → grants alternate 0, 1, 0, 1; `done_id` sequence is 0, 1, 0, 1; no requester is granted twice in a row.
- **Back-pressure:** `done_ready` = 0 for 5 cycles in DONE → `done_valid` and `done_id` stay stable, `req_ready` stays 00, `round_cnt` stays constant; release gives IDLE the next cycle.
- **Mid-round reset:** assert `rst` at `round_cnt` = 5 → all outputs take their reset values in the same cycle. After deassertion, `req_valid` = 10 grants index 1; with `req_valid` = 11, index 0 is granted first.
- **NUM_ROUNDS = 14, CNT_W = 4:** `round_en` lasts 14 cycles, `last_round` is high only at `round_cnt` = 14, and `done_valid` rises at cycle 16 after the grant.
